mul_operand_sequencer: RTL

- Front-end sequencer for the 16-bit repeated-addition multiplier datapath/controller pair.
- Accepts operand pairs on a valid/ready handshake and fires the multiplier's start strobe.
- Serialises A then B onto the multiplier's shared data_in bus in the controller's load cycles, waits for done, and returns the product on a valid/ready output.
- Also short-circuits zero operands, optionally swaps operands to minimise iteration count, guards against a hung multiplier with a watchdog, and pulses a clear so the multiplier can be reused.

---
 rtl/mul_pkg.sv | 18 +
 rtl/mul_watchdog.sv | 33 +++
 rtl/mul_operand_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier operand sequencer: state encoding and
// default sizing constants.
package mul_pkg;

  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 70000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    OUT    = 3'd5,
    CLR    = 3'd6
  } state_t;

endpackage

// File: rtl/mul_watchdog.sv
// Saturating cycle counter that flags a multiplier which has not finished
// within TIMEOUT cycles of waiting.
module mul_watchdog
  import mul_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Holds at LAST instead of wrapping, so expired stays asserted until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mul_operand_sequencer.sv
// Front end for the repeated-addition multiplier: accepts an operand pair,
// serialises A then B onto the multiplier bus, waits for done, returns the product.
module mul_operand_sequencer
  import mul_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_product,
  output logic         out_err,
  output logic         mul_start,
  output logic [W-1:0] mul_data,
  input  logic         mul_done,
  input  logic [W-1:0] mul_result,
  output logic         mul_clr,
  output logic         busy,
  output state_t       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and payload is held while valid
  // is high and ready is low.

  state_t        state, state_d;
  logic [W-1:0]  a_q, b_q, a_nxt, b_nxt, a_sel, b_sel;
  logic [W-1:0]  product_q, product_d, mul_data_d;
  logic          err_q, err_d, zero_q, zero_d;
  logic          swap, is_zero, expired;

  assign swap    = SWAP_EN && (in_b > in_a);
  assign a_sel   = swap ? in_b : in_a;
  assign b_sel   = swap ? in_a : in_b;
  assign is_zero = (in_a == '0) || (in_b == '0);

  mul_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == LOAD_B),
    .en      (state == WAIT),
    .expired (expired)
  );

  always_comb begin
    state_d   = state;
    product_d = product_q;
    err_d     = err_q;
    zero_d    = zero_q;
    a_nxt     = a_q;
    b_nxt     = b_q;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_nxt  = a_sel;
          b_nxt  = b_sel;
          zero_d = is_zero;
          if (is_zero) begin
            product_d = '0;
            err_d     = 1'b0;
            state_d   = OUT;
          end else begin
            state_d = START;
          end
        end
      end
      START:  state_d = LOAD_A;
      LOAD_A: state_d = LOAD_B;
      LOAD_B: state_d = WAIT;
      WAIT: begin
        // done wins over a timeout landing in the same cycle
        if (mul_done) begin
          product_d = mul_result;
          err_d     = 1'b0;
          state_d   = OUT;
        end else if (expired) begin
          product_d = '0;
          err_d     = 1'b1;
          state_d   = OUT;
        end
      end
      OUT:     if (out_ready) state_d = zero_q ? IDLE : CLR;
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    case (state_d)
      START, LOAD_A: mul_data_d = a_nxt;
      LOAD_B, WAIT:  mul_data_d = b_nxt;
      default:       mul_data_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      zero_q    <= 1'b0;
      product_q <= '0;
      err_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mul_start <= 1'b0;
      mul_clr   <= 1'b0;
      busy      <= 1'b0;
      mul_data  <= '0;
    end else begin
      state     <= state_d;
      a_q       <= a_nxt;
      b_q       <= b_nxt;
      zero_q    <= zero_d;
      product_q <= product_d;
      err_q     <= err_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == OUT);
      mul_start <= (state_d == START);
      mul_clr   <= (state_d == CLR);
      busy      <= (state_d != IDLE);
      mul_data  <= mul_data_d;
    end
  end

  assign out_product = product_q;
  assign out_err     = err_q;
  assign dbg_state   = state;

endmodule
